// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//
// Multi-cycle wide adder/subtractor. A WIDTH-bit request is accepted through
// an in_valid/in_ready handshake. One CHUNK-bit adder slice is then reused for
// WIDTH/CHUNK consecutive cycles, least-significant chunk first, with the
// carry chained through a register. The result is offered through an
// out_valid/out_ready handshake and held stable until it is taken.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operand request valid
//   in_ready   out  1      block can accept operands (IDLE only)
//   a, b       in   WIDTH  operands
//   sub        in   1      1 = a - b, 0 = a + b
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, defined while out_valid=1
//   cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  1      two's-complement overflow of the full operation
//   busy       out  1      high in RUN or DONE
// -----------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    // Illegal geometry stops elaboration.
    generate
        if (((WIDTH % CHUNK) != 0) || (CHUNK < 2)) begin : g_bad_params
            $error("wide_add_sequencer: WIDTH must be a multiple of CHUNK and CHUNK must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One slice: returns {carry into slice MSB, carry out, CHUNK-bit sum}.
    // The carry into the MSB comes from adding the lower CHUNK-1 bits alone.
    function automatic logic [CHUNK+1:0] add_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        logic [CHUNK-1:0] lo;
        logic [CHUNK:0]   full;
        lo   = {1'b0, x[CHUNK-2:0]} + {1'b0, y[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, cin};
        full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
        return {lo[CHUNK-1], full};
    endfunction

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_overflow;
    logic               r_carry;
    logic [IDXW-1:0]    r_idx;

    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [CHUNK+1:0]   w_slice;
    logic [CHUNK-1:0]   w_slice_sum;
    logic               w_slice_cout;
    logic               w_msb_cin;

    // Operands shift right each RUN cycle, so the active chunk is always the
    // low CHUNK bits and no variable part-select is needed on the operands.
    assign w_slice      = add_slice(r_op_a[CHUNK-1:0], r_op_b[CHUNK-1:0], r_carry);
    assign w_slice_sum  = w_slice[CHUNK-1:0];
    assign w_slice_cout = w_slice[CHUNK];
    assign w_msb_cin    = w_slice[CHUNK+1];
    assign w_last       = (r_idx == IDXW'(NCH - 1));

    // Next-state decode and request acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                // No same-cycle accept: IDLE is always visited first.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // Datapath: operand latch, chunk-by-chunk accumulation and final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a     <= {WIDTH{1'b0}};
            r_op_b     <= {WIDTH{1'b0}};
            r_sum      <= {WIDTH{1'b0}};
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
            r_idx      <= {IDXW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Subtraction as a + ~b + 1: the +1 enters as carry-in.
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_idx   <= {IDXW{1'b0}};
                        r_sum   <= {WIDTH{1'b0}};
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (r_idx == IDXW'(k)) begin
                            r_sum[k*CHUNK +: CHUNK] <= w_slice_sum;
                        end
                    end
                    r_op_a  <= r_op_a >> CHUNK;
                    r_op_b  <= r_op_b >> CHUNK;
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_idx      <= {IDXW{1'b0}};
                        r_cout     <= w_slice_cout;
                        r_overflow <= w_msb_cin ^ w_slice_cout;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    // Result held stable until consumed.
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

    localparam int W   = 128;
    localparam int C   = 32;
    localparam int NCH = W / C;
    localparam int W1  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Wide instance
    logic         in_valid, in_ready, sub, out_valid, out_ready, cout, overflow, busy;
    logic [W-1:0] a, b, sum;

    // Single-chunk instance
    logic          s_in_valid, s_in_ready, s_sub, s_out_valid, s_out_ready, s_cout, s_overflow, s_busy;
    logic [W1-1:0] s_a, s_b, s_sum;

    wide_add_sequencer #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
    );

    wide_add_sequencer #(.WIDTH(W1), .CHUNK(W1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .sub(s_sub), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .overflow(s_overflow), .busy(s_busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic at width w, signs read from operands.
    task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input int w, output logic [W-1:0] s, output logic c, output logic o);
        logic [W:0] mask, aa, bb, t;
        logic sa, sb, ss;
        mask = ({{W{1'b0}}, 1'b1} << w) - 1;
        aa   = {1'b0, ia} & mask;
        bb   = {1'b0, ib} & mask;
        if (isub) begin
            t = aa - bb;
            c = (aa >= bb);
        end else begin
            t = aa + bb;
            c = t[w];
        end
        t  = t & mask;
        s  = t[W-1:0];
        sa = aa[w-1];
        sb = bb[w-1];
        ss = t[w-1];
        o  = isub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction on either instance; returns result and latency
    // (edges from the accept edge to the first out_valid sample).
    task automatic run_op(input bit d1, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, output logic [W-1:0] rs, output logic rc,
                          output logic ro, output int lat);
        int n;
        if (d1) begin
            s_in_valid = 1'b1; s_a = ia[W1-1:0]; s_b = ib[W1-1:0]; s_sub = isub;
        end else begin
            in_valid = 1'b1; a = ia; b = ib; sub = isub;
        end
        n = 0;
        while (!(d1 ? s_in_ready : in_ready) && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 30) begin
            failures++;
            $display("FAIL accept_timeout actual=%0d required<30", n);
        end
        tick();
        // Operands change after accept and must not disturb the result.
        if (d1) begin
            s_in_valid = 1'b0; s_a = $urandom; s_b = $urandom; s_sub = ~isub;
        end else begin
            in_valid = 1'b0; a = rnd128(); b = rnd128(); sub = ~isub;
        end
        lat = 0;
        while (!(d1 ? s_out_valid : out_valid) && lat < 40) begin
            tick();
            lat++;
        end
        rs = d1 ? {{(W-W1){1'b0}}, s_sum} : sum;
        rc = d1 ? s_cout : cout;
        ro = d1 ? s_overflow : overflow;
        if (d1) s_out_ready = 1'b1; else out_ready = 1'b1;
        tick();
        if (d1) s_out_ready = 1'b0; else out_ready = 1'b0;
        chk("drain_out_valid", {127'd0, d1 ? s_out_valid : out_valid}, 128'd0);
        chk("drain_in_ready",  {127'd0, d1 ? s_in_ready : in_ready},   128'd1);
    endtask

    initial begin
        vec_t         vt[6];
        logic [W-1:0] rs, es;
        logic         rc, ro, ec, eo;
        int           lat;
        logic [W-1:0] ones, msb, maxpos;

        ones   = {W{1'b1}};
        msb    = {1'b1, {(W-1){1'b0}}};
        maxpos = {1'b0, {(W-1){1'b1}}};

        vt[0] = '{a: ones,   b: 128'd1, sub: 1'b0, sum: 128'd0,          cout: 1'b1, ovf: 1'b0};
        vt[1] = '{a: maxpos, b: 128'd1, sub: 1'b0, sum: msb,             cout: 1'b0, ovf: 1'b1};
        vt[2] = '{a: msb,    b: msb,    sub: 1'b0, sum: 128'd0,          cout: 1'b1, ovf: 1'b1};
        vt[3] = '{a: 128'd5, b: 128'd7, sub: 1'b1, sum: ones - 128'd1,   cout: 1'b0, ovf: 1'b0};
        vt[4] = '{a: 128'd7, b: 128'd5, sub: 1'b1, sum: 128'd2,          cout: 1'b1, ovf: 1'b0};
        vt[5] = '{a: msb,    b: 128'd1, sub: 1'b1, sum: maxpos,          cout: 1'b1, ovf: 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy",      {127'd0, busy},      128'd0);
        chk("rst_sum",       sum,                 128'd0);
        chk("rst_cout",      {127'd0, cout},      128'd0);
        chk("rst_overflow",  {127'd0, overflow},  128'd0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, vt[i].a, vt[i].b, vt[i].sub, rs, rc, ro, lat);
            chk($sformatf("vec%0d_sum", i),  rs,              vt[i].sum);
            chk($sformatf("vec%0d_cout", i), {127'd0, rc},    {127'd0, vt[i].cout});
            chk($sformatf("vec%0d_ovf", i),  {127'd0, ro},    {127'd0, vt[i].ovf});
            chk($sformatf("vec%0d_lat", i),  128'(lat),       128'(NCH));
        end

        // Randomized against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            logic         rsub;
            ra = rnd128();
            rb = rnd128();
            rsub = $urandom_range(0, 1);
            case (i % 6)
                0: rb = ra;
                1: ra = ones;
                2: rb = ~ra;
                3: ra = {ra[W-1], {(W-1){~ra[W-1]}}};
                default: ;
            endcase
            run_op(1'b0, ra, rb, rsub, rs, rc, ro, lat);
            model(ra, rb, rsub, W, es, ec, eo);
            chk($sformatf("rnd%0d_sum", i),  rs,           es);
            chk($sformatf("rnd%0d_cout", i), {127'd0, rc}, {127'd0, ec});
            chk($sformatf("rnd%0d_ovf", i),  {127'd0, ro}, {127'd0, eo});
        end

        // Backpressure with input noise during RUN and DONE
        begin
            logic [W-1:0] ra, rb;
            int n;
            ra = rnd128(); rb = rnd128();
            model(ra, rb, 1'b1, W, es, ec, eo);
            a = ra; b = rb; sub = 1'b1; in_valid = 1'b1;
            tick();
            chk("bp_busy_run", {127'd0, busy}, 128'd1);
            n = 0;
            while (!out_valid && n < 40) begin
                a = rnd128(); b = rnd128(); sub = $urandom_range(0, 1); in_valid = $urandom_range(0, 1);
                tick();
                n++;
            end
            chk("bp_lat", 128'(n), 128'(NCH));
            for (int k = 0; k < 3; k++) begin
                a = rnd128(); b = rnd128(); in_valid = $urandom_range(0, 1);
                tick();
                chk($sformatf("bp_hold%0d_sum", k),   sum,                 es);
                chk($sformatf("bp_hold%0d_cout", k),  {127'd0, cout},      {127'd0, ec});
                chk($sformatf("bp_hold%0d_ovf", k),   {127'd0, overflow},  {127'd0, eo});
                chk($sformatf("bp_hold%0d_inrdy", k), {127'd0, in_ready},  128'd0);
                chk($sformatf("bp_hold%0d_valid", k), {127'd0, out_valid}, 128'd1);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
            chk("bp_release_inrdy", {127'd0, in_ready},  128'd1);
        end

        // Reset during the second RUN cycle
        begin
            int seen;
            a = ones; b = 128'd1; sub = 1'b0; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("mid_rst_inrdy", {127'd0, in_ready},  128'd1);
            chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
            chk("mid_rst_busy",  {127'd0, busy},      128'd0);
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("mid_rst_no_result", 128'(seen), 128'd0);
        end

        // Back-to-back with in_valid held and out_ready tied high
        begin
            logic [W-1:0] x1, y1, x2, y2, e1, e2;
            logic         c1, c2, o1, o2;
            logic [W-1:0] got_s[2];
            logic         got_c[2], got_o[2];
            int           acc, nres, acc_cyc[2];
            x1 = rnd128(); y1 = rnd128(); x2 = rnd128(); y2 = rnd128();
            model(x1, y1, 1'b0, W, e1, c1, o1);
            model(x2, y2, 1'b1, W, e2, c2, o2);
            a = x1; b = y1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            acc = 0; nres = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
            for (int k = 0; k < 30; k++) begin
                bit will_acc;
                will_acc = in_valid && in_ready;
                if (out_valid) begin
                    if (nres < 2) begin
                        got_s[nres] = sum; got_c[nres] = cout; got_o[nres] = overflow;
                    end
                    nres++;
                end
                tick();
                if (will_acc) begin
                    if (acc < 2) acc_cyc[acc] = cyc;
                    acc++;
                    if (acc == 1) begin
                        a = x2; b = y2; sub = 1'b1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            out_ready = 1'b0;
            chk("b2b_results", 128'(nres), 128'd2);
            chk("b2b_accepts", 128'(acc),  128'd2);
            if (nres >= 2) begin
                chk("b2b_r0_sum",  got_s[0],            e1);
                chk("b2b_r0_cout", {127'd0, got_c[0]},  {127'd0, c1});
                chk("b2b_r0_ovf",  {127'd0, got_o[0]},  {127'd0, o1});
                chk("b2b_r1_sum",  got_s[1],            e2);
                chk("b2b_r1_cout", {127'd0, got_c[1]},  {127'd0, c2});
                chk("b2b_r1_ovf",  {127'd0, got_o[1]},  {127'd0, o2});
            end
            chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NCH + 2));
        end

        // Single-chunk instance: RUN lasts one cycle
        run_op(1'b1, 128'hFFFF_FFFF, 128'd1, 1'b0, rs, rc, ro, lat);
        chk("w32_sum",  rs,           128'd0);
        chk("w32_cout", {127'd0, rc}, 128'd1);
        chk("w32_ovf",  {127'd0, ro}, 128'd0);
        chk("w32_lat",  128'(lat),    128'd1);
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rsub;
            ra = {96'd0, $urandom};
            rb = {96'd0, $urandom};
            rsub = $urandom_range(0, 1);
            if (i == 0) ra = {96'd0, 32'h7FFF_FFFF};
            run_op(1'b1, ra, rb, rsub, rs, rc, ro, lat);
            model(ra, rb, rsub, W1, es, ec, eo);
            chk($sformatf("w32_rnd%0d_sum", i),  rs,           es);
            chk($sformatf("w32_rnd%0d_cout", i), {127'd0, rc}, {127'd0, ec});
            chk($sformatf("w32_rnd%0d_ovf", i),  {127'd0, ro}, {127'd0, eo});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
